// File: rtl/time_score_display.sv
// rtl/time_score_display.sv - time/score BCD conversion and 4-digit multiplexed 7-segment driver
module time_score_display #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_DIV      = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seconds,
    input  logic [7:0] score,
    input  logic       time_up,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       bcd_valid
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]    AN_OFF    = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

    typedef enum logic [1:0] {IDLE, SHIFT_T, SHIFT_S, COMMIT} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_bit_cnt;
    logic        w_last_bit;
    logic [15:0] r_work, w_work_step;
    logic [7:0]  r_score_op;
    logic [7:0]  r_time_bcd;
    logic [15:0] r_digits;
    logic [SW-1:0] r_scan_cnt;
    logic [1:0]  r_scan_idx;
    logic [BW-1:0] r_blink_cnt;
    logic        r_blink_off;
    logic [6:0]  r_seg;
    logic [3:0]  r_an;
    logic [3:0]  w_nibble;
    logic [6:0]  w_pat;
    logic [3:0]  w_onehot;
    logic        w_blank;

    function automatic logic [7:0] clamp99(input logic [7:0] v);
        return (v > 8'd99) ? 8'd99 : v;
    endfunction

    // One double-dabble step on {bcd[15:8], binary[7:0]}: adjust BCD nibbles, then shift.
    function automatic logic [15:0] dd_step(input logic [15:0] v);
        logic [15:0] a;
        a = v;
        if (a[11:8] >= 4'd5)
            a[11:8] = a[11:8] + 4'd3;
        if (a[15:12] >= 4'd5)
            a[15:12] = a[15:12] + 4'd3;
        return {a[14:0], 1'b0};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign w_work_step = dd_step(r_work);
    assign w_last_bit  = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        bcd_valid   = 1'b0;
        case (r_state)
            IDLE:    w_state_nxt = SHIFT_T;
            SHIFT_T: if (w_last_bit) w_state_nxt = SHIFT_S;
            SHIFT_S: if (w_last_bit) w_state_nxt = COMMIT;
            COMMIT: begin
                bcd_valid   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Both operands are captured in IDLE so the committed pair is always coherent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt  <= 3'd0;
            r_work     <= 16'h0000;
            r_score_op <= 8'h00;
            r_time_bcd <= 8'h00;
            r_digits   <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bit_cnt  <= 3'd0;
                    r_work     <= {8'h00, clamp99(seconds)};
                    r_score_op <= clamp99(score);
                end
                SHIFT_T: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_last_bit) begin
                        r_time_bcd <= w_work_step[15:8];
                        r_work     <= {8'h00, r_score_op};
                    end else begin
                        r_work <= w_work_step;
                    end
                end
                SHIFT_S: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    r_work    <= w_work_step;
                end
                COMMIT:  r_digits <= {r_time_bcd, r_work[15:8]};
                default: r_bit_cnt <= 3'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan_cnt <= '0;
            r_scan_idx <= 2'd0;
        end else if (r_scan_cnt == SCAN_MAX) begin
            r_scan_cnt <= '0;
            r_scan_idx <= r_scan_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (!time_up) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Gating with time_up lets the time digits return the moment the flag drops.
    assign w_blank  = time_up & r_blink_off & r_scan_idx[1];
    assign w_nibble = r_digits[{r_scan_idx, 2'b00} +: 4];
    assign w_pat    = w_blank ? 7'h00 : decode(w_nibble);
    assign w_onehot = 4'b0001 << r_scan_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= SEG_ACTIVE_LOW ? ~w_pat : w_pat;
            r_an  <= SEG_ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_time_score_display.sv
// tb/tb_time_score_display.sv - randomized self-checking bench for time_score_display
module tb_time_score_display;

    localparam int SD = 4;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] seconds = 8'd0;
    logic [7:0] score = 8'd0;
    logic       time_up = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       bcd_valid;

    int checks = 0;
    int failures = 0;
    int k = 0;
    int m = 0;
    int disp[4] = '{0, 0, 0, 0};
    int pend_t = 0;
    int pend_s = 0;
    int first_bv = -1;

    time_score_display #(.SCAN_DIV(SD), .BLINK_DIV(BD), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .seconds(seconds), .score(score),
        .time_up(time_up), .seg(seg), .an(an), .bcd_valid(bcd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] on;
        case (d)
            0: on = 7'h3F; 1: on = 7'h06; 2: on = 7'h5B; 3: on = 7'h4F; 4: on = 7'h66;
            5: on = 7'h6D; 6: on = 7'h7D; 7: on = 7'h07; 8: on = 7'h7F; 9: on = 7'h6F;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

    // Reference: period of 18 cycles counted from reset release; sample on cycle 1, commit on cycle 18.
    task automatic tick();
        int tu, sec, sc, rst_hi, pos, idx;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic e_bv;
        tu = int'(time_up);
        sec = int'(seconds);
        sc = int'(score);
        rst_hi = int'(reset);
        @(posedge clk);
        if (rst_hi == 0) begin
            k = 0; m = 0; pend_t = 0; pend_s = 0;
            for (int i = 0; i < 4; i++) disp[i] = 0;
            e_seg = 7'h7F; e_an = 4'hF; e_bv = 1'b0;
        end else begin
            k++;
            pos = (k - 1) % 18;
            if (pos == 0) begin
                pend_t = (sec > 99) ? 99 : sec;
                pend_s = (sc > 99) ? 99 : sc;
            end
            idx = ((k - 1) / SD) % 4;
            e_an = 4'hF & ~(4'b0001 << idx);
            if (tu == 1 && ((m / BD) % 2) == 1 && idx >= 2)
                e_seg = 7'h7F;
            else
                e_seg = seg_of(disp[idx]);
            if (pos == 17) begin
                disp[3] = pend_t / 10; disp[2] = pend_t % 10;
                disp[1] = pend_s / 10; disp[0] = pend_s % 10;
            end
            m = (tu == 1) ? m + 1 : 0;
            e_bv = ((k % 18) == 17);
        end
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("bcd_valid", 32'(bcd_valid), 32'(e_bv));
        if (bcd_valid === 1'b1 && first_bv < 0) first_bv = k;
    endtask

    task automatic assert_reset_now();
        reset = 1'b0;
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_bv", 32'(bcd_valid), 32'h0);
    endtask

    initial begin
        #2;
        assert_reset_now();
        for (int i = 0; i < 3; i++) tick();

        seconds = 8'd60; score = 8'd7;
        reset = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk("first_commit_cycle", 32'(first_bv + 1), 32'd18);

        seconds = 8'd150; score = 8'd255;
        for (int i = 0; i < 40; i++) tick();

        seconds = 8'd0; score = 8'd12; time_up = 1'b1;
        for (int i = 0; i < 48; i++) tick();
        time_up = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        seconds = 8'd60;
        while ((k % 18) != 2) tick();
        seconds = 8'd59;
        for (int i = 0; i < 40; i++) tick();

        while ((k % 18) != 10) tick();
        assert_reset_now();
        for (int i = 0; i < 3; i++) tick();
        seconds = 8'd42; score = 8'd99;
        reset = 1'b1;
        first_bv = -1;
        for (int i = 0; i < 20; i++) tick();
        chk("commit_after_reset", 32'(first_bv + 1), 32'd18);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) seconds = 8'($urandom);
            if ($urandom_range(0, 19) == 0) score = 8'($urandom);
            if ($urandom_range(0, 39) == 0) time_up = ~time_up;
            if ($urandom_range(0, 499) == 0) begin
                assert_reset_now();
                tick();
                reset = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
